sound_sequencer: RTL and testbench

// Note sequencer in front of the pulse/noise tone generator. Accepts queued note commands
// (period, volume, width, duration), drives the generator's period/volume/width settings
// for each note's lifetime, and applies a linear attack/release volume envelope at a fixed tick rate.

---
 rtl/sound_pkg.sv | 34 +++
 rtl/sound_cmd_fifo.sv | 57 +++++
 rtl/sound_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_sound_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sound_pkg
// Brief   : Shared types and constants for the note sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package sound_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ATTACK  = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4,
        REST    = 3'd5,
        DONE    = 3'd6
    } seq_state_t;

    localparam logic [15:0] DEFAULT_PERIOD = 16'h377D;
    localparam logic [2:0]  DEFAULT_WIDTH  = 3'd3;
    localparam int          VOL_W          = 5;

    // Command word layout: {period, volume, width, duration}
    localparam int PERIOD_W   = 16;
    localparam int WIDTH_W    = 3;
    localparam int DUR_W      = 8;
    localparam int CMD_W      = PERIOD_W + VOL_W + WIDTH_W + DUR_W;
    localparam int DUR_LSB    = 0;
    localparam int WIDTH_LSB  = DUR_LSB + DUR_W;
    localparam int VOL_LSB    = WIDTH_LSB + WIDTH_W;
    localparam int PERIOD_LSB = VOL_LSB + VOL_W;

endpackage
`default_nettype wire

// File: rtl/sound_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sound_cmd_fifo
// Brief   : Synchronous command FIFO with flush and full/empty flags.
// Revision: 1.0 - initial release
// ============================================================================
module sound_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wr_ptr;
    logic [c_aw:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_push;
    logic               w_pop;

    // Flush wins over both ports so an aborted cycle never moves data.
    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                      (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign pop_data = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : sound_sequencer
// Brief   : Queued note player driving tone-generator settings with a
//           linear attack/release volume envelope.
// Revision: 1.0 - initial release
// ============================================================================
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int QDEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic [VOL_W-1:0]    cmd_volume,
    input  logic [WIDTH_W-1:0]  cmd_width,
    input  logic [DUR_W-1:0]    cmd_duration,
    input  logic                abort,
    output logic [PERIOD_W-1:0] gen_period,
    output logic [VOL_W-1:0]    gen_volume,
    output logic [WIDTH_W-1:0]  gen_width,
    output logic                busy,
    output logic                note_done
);

    localparam int                c_tick_w    = $clog2(TICK_DIV);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);

    seq_state_t          r_state,      w_state_nxt;
    logic [PERIOD_W-1:0] r_gen_period, w_period_nxt;
    logic [VOL_W-1:0]    r_gen_volume, w_volume_nxt;
    logic [WIDTH_W-1:0]  r_gen_width,  w_width_nxt;
    logic [VOL_W-1:0]    r_target,     w_target_nxt;
    logic [DUR_W-1:0]    r_dur_ctr,    w_dur_nxt;
    logic [c_tick_w-1:0] r_tick_ctr,   w_tick_nxt;

    logic                w_push;
    logic                w_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CMD_W-1:0]    w_push_data;
    logic [CMD_W-1:0]    w_pop_data;
    logic [PERIOD_W-1:0] w_ld_period;
    logic [VOL_W-1:0]    w_ld_volume;
    logic [WIDTH_W-1:0]  w_ld_width;
    logic [DUR_W-1:0]    w_ld_dur;
    logic                w_tick;
    logic                w_dur_last;

    assign cmd_ready = !w_fifo_full && !abort;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == LOAD) && !abort;

    always_comb begin
        w_push_data                           = '0;
        w_push_data[PERIOD_LSB +: PERIOD_W]   = cmd_period;
        w_push_data[VOL_LSB    +: VOL_W]      = cmd_volume;
        w_push_data[WIDTH_LSB  +: WIDTH_W]    = cmd_width;
        w_push_data[DUR_LSB    +: DUR_W]      = cmd_duration;
    end

    assign w_ld_period = w_pop_data[PERIOD_LSB +: PERIOD_W];
    assign w_ld_volume = w_pop_data[VOL_LSB    +: VOL_W];
    assign w_ld_width  = w_pop_data[WIDTH_LSB  +: WIDTH_W];
    assign w_ld_dur    = w_pop_data[DUR_LSB    +: DUR_W];

    sound_cmd_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (abort),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign w_tick     = (r_tick_ctr == c_tick_last);
    assign w_dur_last = (r_dur_ctr == DUR_W'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_gen_period;
        w_volume_nxt = r_gen_volume;
        w_width_nxt  = r_gen_width;
        w_target_nxt = r_target;
        w_dur_nxt    = r_dur_ctr;
        w_tick_nxt   = w_tick ? '0 : r_tick_ctr + c_tick_w'(1);

        case (r_state)
            IDLE: begin
                w_tick_nxt   = '0;
                w_volume_nxt = '0;
                if (!w_fifo_empty) w_state_nxt = LOAD;
            end
            LOAD: begin
                w_tick_nxt   = '0;
                w_target_nxt = w_ld_volume;
                w_dur_nxt    = (w_ld_dur == '0) ? DUR_W'(1) : w_ld_dur;
                w_width_nxt  = w_ld_width;
                // A rest leaves the generator period where the last note put it.
                if (w_ld_period != '0) begin
                    w_period_nxt = w_ld_period;
                    w_state_nxt  = ATTACK;
                end else begin
                    w_state_nxt  = REST;
                end
            end
            ATTACK: begin
                if (w_tick) begin
                    w_dur_nxt = r_dur_ctr - DUR_W'(1);
                    if (r_gen_volume < r_target) w_volume_nxt = r_gen_volume + VOL_W'(1);
                end
                if (w_tick && w_dur_last)          w_state_nxt = RELEASE;
                else if (r_gen_volume == r_target) w_state_nxt = SUSTAIN;
            end
            SUSTAIN: begin
                if (w_tick) begin
                    w_dur_nxt = r_dur_ctr - DUR_W'(1);
                    if (w_dur_last) w_state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (r_gen_volume == '0) begin
                    w_state_nxt = DONE;
                end else if (w_tick) begin
                    w_volume_nxt = r_gen_volume - VOL_W'(1);
                    if (r_gen_volume == VOL_W'(1)) w_state_nxt = DONE;
                end
            end
            REST: begin
                w_volume_nxt = '0;
                if (w_tick) begin
                    w_dur_nxt = r_dur_ctr - DUR_W'(1);
                    if (w_dur_last) w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = w_fifo_empty ? IDLE : LOAD;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Abort overrides everything, including a LOAD in progress.
        if (abort) begin
            w_state_nxt  = IDLE;
            w_volume_nxt = '0;
            w_tick_nxt   = '0;
            w_period_nxt = r_gen_period;
            w_width_nxt  = r_gen_width;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_gen_period <= DEFAULT_PERIOD;
            r_gen_volume <= '0;
            r_gen_width  <= DEFAULT_WIDTH;
            r_target     <= '0;
            r_dur_ctr    <= '0;
            r_tick_ctr   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_gen_period <= w_period_nxt;
            r_gen_volume <= w_volume_nxt;
            r_gen_width  <= w_width_nxt;
            r_target     <= w_target_nxt;
            r_dur_ctr    <= w_dur_nxt;
            r_tick_ctr   <= w_tick_nxt;
        end
    end

    assign gen_period = r_gen_period;
    assign gen_volume = r_gen_volume;
    assign gen_width  = r_gen_width;
    assign note_done  = (r_state == DONE);
    assign busy       = (r_state != IDLE) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sound_sequencer
// Brief   : Bench for sound_sequencer using a schedule-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sound_sequencer;

    localparam int TICK_DIV = 4;
    localparam int QDEPTH   = 4;
    localparam int NEVER    = 32'h7fffffff;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_period;
    logic [4:0]  cmd_volume;
    logic [2:0]  cmd_width;
    logic [7:0]  cmd_duration;
    logic        abort;
    logic [15:0] gen_period;
    logic [4:0]  gen_volume;
    logic [2:0]  gen_width;
    logic        busy;
    logic        note_done;

    sound_sequencer #(
        .TICK_DIV (TICK_DIV),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_period   (cmd_period),
        .cmd_volume   (cmd_volume),
        .cmd_width    (cmd_width),
        .cmd_duration (cmd_duration),
        .abort        (abort),
        .gen_period   (gen_period),
        .gen_volume   (gen_volume),
        .gen_width    (gen_width),
        .busy         (busy),
        .note_done    (note_done)
    );

    always #5 clk = ~clk;

    // Each accepted note is a schedule entry: accept edge, LOAD cycle, length
    // of the played window after LOAD, and the cycle an abort cut it off.
    typedef struct {
        int per; int vol; int wid; int dur;
        int acc; int s; int len; int kill;
        bit rest;
    } note_t;

    note_t notes[$];
    int    next_free;
    int    cyc;
    int    errors;
    int    checks;
    int    nd_seen;
    bit    last_acc;

    function automatic int eff_dur(int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int peak(note_t n);
        return (eff_dur(n.dur) < n.vol) ? eff_dur(n.dur) : n.vol;
    endfunction

    function automatic int note_len(note_t n);
        int d = eff_dur(n.dur);
        if (n.rest)        return d * TICK_DIV;
        if (peak(n) > 0)   return (d + peak(n)) * TICK_DIV;
        return d * TICK_DIV + 1;
    endfunction

    // Volume k cycles after LOAD: rises 1/tick up to target while held,
    // then falls 1/tick from wherever it got to.
    function automatic int env_vol(note_t n, int k);
        int t = k / TICK_DIV;
        int d = eff_dur(n.dur);
        if (n.rest) return 0;
        if (t <= d) return (t < n.vol) ? t : n.vol;
        return (peak(n) - (t - d) > 0) ? peak(n) - (t - d) : 0;
    endfunction

    task automatic model_at(input int c, output int vol, output int per, output int wid,
                            output bit done, output bit bsy, output int occ);
        vol = 0; per = 16'h377D; wid = 3; done = 0; bsy = 0; occ = 0;
        foreach (notes[i]) begin
            note_t n;
            n = notes[i];
            if (c < n.kill) begin
                if (n.acc <= c && c <= n.s) occ++;
                if (n.acc <= c && c <= n.s + n.len + 1) bsy = 1'b1;
                if (c > n.s && c <= n.s + n.len) vol = env_vol(n, c - n.s - 1);
                if (c == n.s + n.len + 1) done = 1'b1;
            end
            if (c >= n.s + 1) begin
                wid = n.wid;
                if (!n.rest) per = n.per;
            end
        end
    endtask

    task automatic add_note(input int edge_n);
        note_t n;
        n.per  = int'(cmd_period);
        n.vol  = int'(cmd_volume);
        n.wid  = int'(cmd_width);
        n.dur  = int'(cmd_duration);
        n.rest = (cmd_period == 16'd0);
        n.acc  = edge_n;
        n.s    = (edge_n + 1 > next_free) ? edge_n + 1 : next_free;
        n.len  = note_len(n);
        n.kill = NEVER;
        next_free = n.s + n.len + 2;
        notes.push_back(n);
    endtask

    task automatic apply_abort(input int a);
        for (int i = notes.size() - 1; i >= 0; i--) begin
            if (notes[i].s + 1 >= a) notes.delete(i);
            else if (notes[i].kill > a) notes[i].kill = a;
        end
        next_free = a;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_now();
        int v, p, w, o;
        bit d, b;
        model_at(cyc, v, p, w, d, b, o);
        chk("gen_volume", 32'(gen_volume), v);
        chk("gen_period", 32'(gen_period), p);
        chk("gen_width",  32'(gen_width),  w);
        chk("note_done",  32'(note_done),  32'(d));
        chk("busy",       32'(busy),       32'(b));
        chk("cmd_ready",  32'(cmd_ready),  32'((o < QDEPTH) && !abort));
        if (note_done === 1'b1) nd_seen++;
    endtask

    task automatic step();
        int v, p, w, o;
        bit d, b, ab, acc;
        model_at(cyc, v, p, w, d, b, o);
        ab  = abort;
        acc = cmd_valid && (o < QDEPTH) && !abort && reset_n;
        @(posedge clk);
        cyc++;
        last_acc = 1'b0;
        if (!reset_n) begin
            notes.delete();
            next_free = 0;
        end else if (ab) begin
            apply_abort(cyc);
        end else if (acc) begin
            add_note(cyc);
            last_acc = 1'b1;
        end
        #1;
        check_now();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input int per, input int vol, input int wid, input int dur);
        int waited = 0;
        cmd_valid    = 1'b1;
        cmd_period   = 16'(per);
        cmd_volume   = 5'(vol);
        cmd_width    = 3'(wid);
        cmd_duration = 8'(dur);
        do begin
            step();
            waited++;
        end while (!last_acc && waited < 2000);
        if (!last_acc) begin
            checks++;
            errors++;
            $error("FAIL push_timeout cyc=%0d observed=not_accepted expected=accepted", cyc);
        end
        cmd_valid = 1'b0;
    endtask

    function automatic bit model_busy(input int c);
        foreach (notes[i])
            if (c < notes[i].kill && c <= notes[i].s + notes[i].len + 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_until_idle();
        int n = 0;
        while ((model_busy(cyc) || busy === 1'b1) && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $error("FAIL idle_timeout cyc=%0d observed=busy expected=idle", cyc);
        end
        steps(2);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_period"}, 32'(gen_period), 32'h377D);
        chk({tag, "_volume"}, 32'(gen_volume), 0);
        chk({tag, "_width"},  32'(gen_width),  3);
        chk({tag, "_done"},   32'(note_done),  0);
        chk({tag, "_busy"},   32'(busy),       0);
        chk({tag, "_ready"},  32'(cmd_ready),  1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0; cyc = 0; next_free = 0; nd_seen = 0; last_acc = 1'b0;
        reset_n = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_period = '0; cmd_volume = '0; cmd_width = '0; cmd_duration = '0;
        #2 reset_n = 1'b0;
        steps(2);
        reset_n = 1'b1;
        step();
        check_reset_vals("t1_reset");

        // Basic note with full attack, sustain and release.
        nd_seen = 0;
        push(1000, 4, 2, 10);
        run_until_idle();
        chk("t2_done_count", nd_seen, 1);

        // Queue fills behind a long note; a fifth push waits for a pop.
        push(1234, 20, 5, 60);
        for (int i = 0; i < 4; i++) push(100 + i, 2, i, 1);
        chk("t3_full_ready", 32'(cmd_ready), 0);
        push(200, 3, 7, 2);
        run_until_idle();

        // Duration shorter than the attack ramp.
        push(500, 8, 1, 2);
        run_until_idle();

        // Note followed by a rest.
        nd_seen = 0;
        push(700, 6, 4, 3);
        push(0, 5, 0, 3);
        run_until_idle();
        chk("t5_done_count", nd_seen, 2);
        chk("t5_period_kept", 32'(gen_period), 700);

        // Abort mid-sustain with commands queued and one presented.
        push(900, 3, 1, 40);
        push(901, 2, 2, 2);
        push(902, 2, 3, 2);
        steps(25);
        nd_seen = 0;
        abort = 1'b1; cmd_valid = 1'b1; cmd_period = 16'd777;
        cmd_volume = 5'd5; cmd_width = 3'd5; cmd_duration = 8'd5;
        #1 chk("t6_ready_during_abort", 32'(cmd_ready), 0);
        step();
        abort = 1'b0; cmd_valid = 1'b0;
        chk("t6_vol_after_abort", 32'(gen_volume), 0);
        chk("t6_busy_after_abort", 32'(busy), 0);
        steps(10);
        chk("t6_no_done", nd_seen, 0);

        // Asynchronous reset in the middle of a note.
        push(1500, 9, 6, 30);
        steps(20);
        reset_n = 1'b0;
        #1 check_reset_vals("t6_async_reset");
        step();
        reset_n = 1'b1;
        steps(2);

        // Randomized commands, including rests and zero durations.
        for (int i = 0; i < 14; i++) begin
            int per;
            per = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 65535));
            push(per, int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 6)));
            steps(int'($urandom_range(0, 3)));
        end
        run_until_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
